data_mem_port: RTL
==================

# data_mem_port

Load/store unit sitting directly downstream of the single-cycle datapath: it consumes `ALUResult`, `WriteData` and the controller's `MemRead`/`MemWrite` strobes, and produces `ReadData` for the datapath's byte-load result mux. It bridges the core to a variable-latency, byte-wide memory bus through a req/ack handshake. It posts stores through a one-entry store buffer and raises `Stall` so the core freezes its PC and register writes while an access is outstanding.

## Interface
Parameters:
- `MEM_AW`, 16: memory bus address width; core addresses with any of bits [31:MEM_AW] set are out of range.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack` before aborting an access.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  load request from controller; held stable while `Stall`=1.
- `MemWrite`  in  1  store request from controller; held stable while `Stall`=1.
- `ALUResult`  in  32  byte address.
- `WriteData`  in  32  store data; only [7:0] is written.
- `ReadData`  out  32  load result: {24'b0, byte}.
- `Stall`  out  1  combinational; 1 = core must hold the current instruction.
- `MemFault`  out  1  one-cycle pulse on an out-of-range access or a timeout.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  1  bus write enable, registered.
- `mem_addr`  out  MEM_AW  bus address, registered.
- `mem_wdata`  out  8  bus write byte, registered.
- `mem_ack`  in  1  bus completion; transaction ends in the cycle it is sampled high.
- `mem_rdata`  in  8  read byte; valid when `mem_ack`=1 on a read.

## Operation
- Store buffer: one entry {valid, addr, byte}. Stores retire into it and drain to the bus in the background.
- FSM states:
  - IDLE.
  - WR_BUSY: buffer draining.
  - RD_WAIT: read outstanding.
  - RD_DONE: read data presented to the core.
- Store, buffer empty: captured at the clock edge; `Stall`=0 (posted).
- Store, buffer full: `Stall`=1 until the drain acks; then captured.
- Load, buffer valid with equal address: forward the buffered byte combinationally; `Stall`=0; no bus read.
- Load, buffer valid with different address: `Stall`=1; drain first, then read. Write-before-read order is preserved.
- Load, buffer empty: `Stall`=1; issue the read. On ack, latch `mem_rdata`, go to RD_DONE. RD_DONE drives `Stall`=0 for one cycle, then returns to IDLE. RD_DONE never re-issues the request.
- Out of range (any bit of `ALUResult[31:MEM_AW]` set):
  - No bus transaction.
  - `MemFault` pulses.
  - `Stall`=0, `ReadData`=0.
  - A store is dropped.
- Timeout: counter starts at `mem_req` rise and clears on ack. On reaching `TIMEOUT`:
  - Drop `mem_req` next cycle and pulse `MemFault`.
  - A timed-out load completes via RD_DONE with byte 0.
  - A timed-out drain discards the buffer entry.
- `MemRead` and `MemWrite` both high: treated as a store.
- Bus outputs hold stable while `mem_req`=1 and `mem_ack`=0.

## Timing
- Reset values: `ReadData`=0, `Stall`=0, `MemFault`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Buffer invalid, FSM in IDLE, counter 0.
- Reset mid-transaction: `mem_req` drops asynchronously and the buffered store is lost.
- Posted store in cycle N: buffer valid and `mem_req`=1, `mem_we`=1 in cycle N+1.
- Ack in cycle M: buffer empty in M+1. Any pending access raises `mem_req` in M+1 (no bubble).
- Load in cycle N with buffer empty: `mem_req` in N+1. Ack in M gives RD_DONE in M+1; the core advances at the end of M+1.
- Minimum load occupancy is 3 cycles.
- `MemFault` is asserted for exactly one cycle per event.

## Structure
- Package `mem_pkg`: state enum (IDLE, WR_BUSY, RD_WAIT, RD_DONE), store-buffer entry struct, default `TIMEOUT` constant.
- Sub-module `store_buffer`: one-entry register with load/clear/address-match output. FSM, timeout counter and bus registers stay in the top module.

## Test plan
- Store 0xAB to address 0x10 with `mem_ack` returned 2 cycles after req → `Stall` stays 0; `mem_req`/`mem_we`=1 for 3 cycles with `mem_addr`=0x10, `mem_wdata`=0xAB.
- Store to 0x10, then an immediate load from 0x10 → `ReadData`=0x000000AB in the same cycle; `Stall`=0; no read request on the bus.
- Store to 0x10 (held unacked), then load from 0x20 → drain completes first, read of 0x20 issues next cycle; `ReadData`={24'b0, `mem_rdata`} in RD_DONE.
- Two back-to-back stores with ack delayed 4 cycles → second store sees `Stall`=1 until the first ack, then posts.
- Load from 0x0001_0000 with `MEM_AW`=16 → `MemFault` pulse, `ReadData`=0, no `mem_req`.
- Load with `mem_ack` never asserted, `TIMEOUT`=8 → `mem_req` drops after 8 cycles, `MemFault` pulses, RD_DONE returns 0; asserting `rst`=0 mid-wait clears all outputs immediately.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data-memory load/store port: FSM states, store-buffer entry, defaults.
package mem_pkg;

  localparam int unsigned CORE_AW     = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [CORE_AW-1:0]  addr;
    logic [BYTE_W-1:0]   data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// One-entry posted-store buffer; flags when the current core address matches the held store.
module store_buffer
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  sb_entry_t          load_entry,
  input  logic [CORE_AW-1:0] match_addr,
  output logic               valid,
  output logic [BYTE_W-1:0]  data,
  output logic               hit_c
);

  sb_entry_t entry;

  // A new capture wins over a clear so a drain-ack and a back-to-back store can share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (load) begin
      entry <= load_entry;
    end else if (clear) begin
      entry.valid <= 1'b0;
    end
  end

  assign valid = entry.valid;
  assign data  = entry.data;
  assign hit_c = entry.valid && (entry.addr == match_addr);

endmodule

// File: rtl/data_mem_port.sv
// Load/store unit bridging the single-cycle core to a byte-wide req/ack memory bus,
// with a one-entry posted store buffer, store-to-load forwarding and a bus timeout.
module data_mem_port
  import mem_pkg::*;
#(
  parameter int unsigned MEM_AW  = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              MemFault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       rd_byte;

  logic             sb_valid;
  logic [7:0]       sb_data;
  logic             sb_hit;
  sb_entry_t        sb_new;

  logic is_st, is_ld, oor, open_c, bad, tmo_hit;
  logic drain_ack, accept_st, issue_rd, fwd, sb_clear, stall_raw;
  logic unused_wdata_hi;

  assign unused_wdata_hi = ^WriteData[31:8];

  // Access decode; a simultaneous read+write strobe is a store.
  always_comb begin
    is_st     = MemWrite;
    is_ld     = MemRead && !MemWrite;
    oor       = (ALUResult >> MEM_AW) != 32'd0;
    open_c    = (state == IDLE) || (state == WR_BUSY);
    bad       = open_c && (is_st || is_ld) && oor;
    tmo_hit   = mem_req && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
    drain_ack = (state == WR_BUSY) && mem_ack;
    accept_st = open_c && is_st && !oor && (!sb_valid || drain_ack);
    fwd       = open_c && is_ld && !oor && sb_hit;
    issue_rd  = open_c && is_ld && !oor && !sb_hit && (!sb_valid || drain_ack);
    sb_clear  = drain_ack || ((state == WR_BUSY) && tmo_hit);
    sb_new    = '{valid: 1'b1, addr: ALUResult, data: WriteData[7:0]};
  end

  // Core hold: pending store needs a free slot, a load needs forwarding or RD_DONE.
  always_comb begin
    stall_raw = 1'b0;
    case (state)
      IDLE, WR_BUSY: stall_raw = (is_st && !oor && !accept_st) || (is_ld && !oor && !fwd);
      RD_WAIT:       stall_raw = 1'b1;
      default:       stall_raw = 1'b0;
    endcase
  end

  assign Stall    = rst && stall_raw;
  assign ReadData = {24'd0, bad ? 8'h00 : (fwd ? sb_data : rd_byte)};

  store_buffer u_sb (
    .clk        (clk),
    .rst_n      (rst),
    .load       (accept_st),
    .clear      (sb_clear),
    .load_entry (sb_new),
    .match_addr (ALUResult),
    .valid      (sb_valid),
    .data       (sb_data),
    .hit_c      (sb_hit)
  );

  // FSM, bus registers and timeout counter; a new issue can follow an ack with no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_byte   <= 8'h00;
      MemFault  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
    end else begin
      MemFault <= bad;
      if (accept_st || issue_rd) begin
        mem_req   <= 1'b1;
        mem_we    <= accept_st;
        mem_addr  <= ALUResult[MEM_AW-1:0];
        mem_wdata <= accept_st ? WriteData[7:0] : 8'h00;
        cnt       <= '0;
        state     <= accept_st ? WR_BUSY : RD_WAIT;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
          end
          WR_BUSY: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              state   <= IDLE;
            end else if (tmo_hit) begin
              mem_req  <= 1'b0;
              mem_we   <= 1'b0;
              MemFault <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RD_WAIT: begin
            if (mem_ack) begin
              rd_byte <= mem_rdata;
              mem_req <= 1'b0;
              state   <= RD_DONE;
            end else if (tmo_hit) begin
              rd_byte  <= 8'h00;
              mem_req  <= 1'b0;
              MemFault <= 1'b1;
              state    <= RD_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RD_DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
